uart_scoreboard: RTL and testbench
==================================

Name: uart_scoreboard

Overview:
Synthesisable, parametrised UART receive checker. It replaces the bench-only "expected rx" loop in the ice51 top-level test with a reusable block that runs on FPGA or in simulation. Expected characters are pushed into an internal FIFO, and the block is then armed. Each frame seen on the monitored line is deserialised and compared in order against the FIFO. After the last expected frame, a quiet window must pass with no further traffic. The block reports pass, or fail with a cause code.

Parameters:
CLK_DIV, 104, clock cycles per UART bit (12 MHz / 115200); minimum 4.
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
DEPTH, 128, expected-FIFO entries; power of two.
QUIET_CYCLES, 10000, cycles of line-high required after the last match.
TIMEOUT_CYCLES, 120000000, cycles from arm to verdict before a timeout fail.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_uart  in  1  monitored UART line, asynchronous, idle high
i_exp_valid  in  1  push an expected character
i_exp_data  in  DATA_BITS  expected character
o_exp_ready  out  1  FIFO not full and state IDLE
i_arm  in  1  single-cycle pulse: start checking
o_rx_valid  out  1  one-cycle pulse per received frame
o_rx_data  out  DATA_BITS  last received character
o_rx_count  out  $clog2(DEPTH)+1  frames matched so far
o_busy  out  1  armed, verdict pending
o_pass  out  1  sticky pass
o_fail  out  1  sticky fail
o_fail_code  out  3  1 = mismatch, 2 = unwanted frame, 3 = framing/parity, 4 = timeout

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE and the FIFO is empty.
  - All outputs are 0 except o_exp_ready = 1.
  - The i_uart synchroniser flops reset to 1.
- i_uart passes through a 2-flop synchroniser; the bit-timing latency is 2 cycles.
- FIFO push:
  - Accepted only when i_exp_valid && o_exp_ready.
  - A push while full or while not IDLE is ignored and the FIFO is unchanged.
- Arming:
  - i_arm in IDLE moves to HUNT, sets o_busy, and clears the counters and the timeout counter.
  - i_arm in any other state is ignored.
  - Arming with an empty FIFO goes directly to QUIET.
- States:
  - IDLE.
  - HUNT: wait for the synchronised line to fall 1 -> 0.
  - START: wait CLK_DIV/2 cycles, then resample. If the line is high, the start was a glitch: return to HUNT with no error.
  - DATA: sample every CLK_DIV cycles at bit centre, DATA_BITS samples.
  - PAR: present only if PARITY != 0.
  - STOP: one sample.
  - CHECK: one cycle.
  - QUIET.
  - PASS and FAIL: terminal until reset or i_arm. i_arm from PASS/FAIL clears the flags, keeps the FIFO contents and returns to IDLE.
- Frame errors: a stop bit sampled 0, or a parity mismatch, gives FAIL with code 3.
- CHECK cycle:
  - o_rx_valid pulses and o_rx_data updates.
  - If the FIFO is empty (a frame arrived beyond the expected list), go to FAIL with code 2.
  - Otherwise compare with the FIFO head. On mismatch, go to FAIL with code 1 and do not pop.
  - On match, pop and increment o_rx_count. If the FIFO is now empty go to QUIET, else go to HUNT.
- QUIET:
  - The counter counts up while the line is high.
  - Any falling edge goes to FAIL with code 2; the frame is not decoded.
  - Reaching QUIET_CYCLES goes to PASS.
- Global timeout:
  - The counter runs in every non-terminal armed state.
  - Reaching TIMEOUT_CYCLES goes to FAIL with code 4. Timeout has priority over a simultaneous CHECK result.
- Verdict outputs:
  - o_pass and o_fail are mutually exclusive and are set in the cycle the state enters PASS/FAIL.
  - o_busy clears in that same cycle.
  - o_fail_code holds its value until the next arm or reset.
- Back-to-back frames: a new start edge may arrive one bit after the stop-bit sample, and must be detected. HUNT is re-entered from CHECK without losing an edge that occurs during CHECK.
- Reset mid-frame aborts immediately; the next frame starts only from IDLE.
- The FIFO pointers are $clog2(DEPTH)+1 bits wide, with the MSB used for full/empty detection, and wrap modulo 2*DEPTH.

Test Plan:
- Push 0x48,0x69; arm; drive "H","i" at CLK_DIV = 104, then idle -> two o_rx_valid pulses, o_rx_count = 2, o_pass = 1 exactly QUIET_CYCLES cycles after the second CHECK.
- Push 0x55; drive 0x54 -> o_fail = 1, o_fail_code = 1, o_rx_data = 0x54, o_rx_count = 0.
- Push 0xA5; drive 0xA5 then 0x00 after 2000 cycles -> o_fail_code = 2, o_rx_count = 1.
- PARITY = 1: drive 0x03 with parity bit 1 -> o_fail_code = 3. Then rerun with a stop bit of 0 and a correct parity bit -> o_fail_code = 3.
- Fill the FIFO with DEPTH entries, attempt one more push (o_exp_ready = 0) and check it is ignored. Match all DEPTH frames back-to-back, with the start bit immediately after the stop bit, to verify pointer wrap -> pass, o_rx_count = DEPTH.
- Drive a 10-cycle low glitch in HUNT -> no o_rx_valid. Then assert no traffic with TIMEOUT_CYCLES = 5000 -> o_fail_code = 4. Then assert i_rst mid-DATA and check that all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_scoreboard.sv
// uart_scoreboard: receives UART frames from a monitored line and checks them,
// in order, against a FIFO of expected characters. After the last expected
// frame the line must stay quiet for QUIET_CYCLES before a pass is reported.
// Any mismatch, extra frame, framing/parity error or global timeout gives a
// sticky fail with a cause code.
//
// Handshakes: a character is pushed on any cycle where i_exp_valid and
// o_exp_ready are both high; o_exp_ready is high only in IDLE with space free.
// i_arm is a single-cycle pulse acted on in IDLE, PASS and FAIL only.
// o_rx_valid is a single-cycle pulse with o_rx_data valid in the same cycle.
module uart_scoreboard #(
    parameter int CLK_DIV        = 104,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int DEPTH          = 128,
    parameter int QUIET_CYCLES   = 10000,
    parameter int TIMEOUT_CYCLES = 120000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_uart,
    input  logic                   i_exp_valid,
    input  logic [DATA_BITS-1:0]   i_exp_data,
    output logic                   o_exp_ready,
    input  logic                   i_arm,
    output logic                   o_rx_valid,
    output logic [DATA_BITS-1:0]   o_rx_data,
    output logic [$clog2(DEPTH):0] o_rx_count,
    output logic                   o_busy,
    output logic                   o_pass,
    output logic                   o_fail,
    output logic [2:0]             o_fail_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(CLK_DIV + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] FULL_BIT   = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] HALF_BIT   = BW'(CLK_DIV / 2 - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HUNT, S_START, S_DATA, S_PAR, S_STOP, S_CHECK, S_QUIET, S_PASS, S_FAIL
    } state_t;

    state_t               state;
    logic                 sync1, sync2, line_d;
    logic                 line, fall;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full, last_entry, push;
    logic [DATA_BITS-1:0] head;
    logic [BW-1:0]        tmr;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, par_err;
    logic [QW-1:0]        qcnt;
    logic [TW-1:0]        tmo;

    assign line       = sync2;
    assign fall       = line_d & ~sync2;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign last_entry = ((rd_ptr + PW'(1)) == wr_ptr);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign o_exp_ready = !fifo_full && (state == S_IDLE);
    assign push       = i_exp_valid && o_exp_ready;

    // Two-flop synchroniser plus one delay flop for falling-edge detection; idle high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= i_uart;
            sync2  <= sync1;
            line_d <= sync2;
        end
    end

    // Expected-character storage; pointers live in the FSM block.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= i_exp_data;
    end

    // Parity error of the frame just shifted in (never set when parity is off).
    always_comb begin
        par_err = 1'b0;
        if (PARITY == 1)      par_err = (^shreg) ^ par_bit;
        else if (PARITY == 2) par_err = ~((^shreg) ^ par_bit);
    end

    // Main FSM: arming, frame deserialisation, checking, quiet window, verdict.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tmr         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            qcnt        <= '0;
            tmo         <= '0;
            o_rx_valid  <= 1'b0;
            o_rx_data   <= '0;
            o_rx_count  <= '0;
            o_busy      <= 1'b0;
            o_pass      <= 1'b0;
            o_fail      <= 1'b0;
            o_fail_code <= '0;
        end else begin
            o_rx_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            case (state)
                S_IDLE: begin
                    if (i_arm) begin
                        o_busy      <= 1'b1;
                        o_pass      <= 1'b0;
                        o_fail      <= 1'b0;
                        o_fail_code <= '0;
                        o_rx_count  <= '0;
                        tmo         <= '0;
                        qcnt        <= '0;
                        state       <= fifo_empty ? S_QUIET : S_HUNT;
                    end
                end
                S_PASS, S_FAIL: begin
                    if (i_arm) begin
                        o_pass      <= 1'b0;
                        o_fail      <= 1'b0;
                        o_fail_code <= '0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    // Timeout wins over whatever the current state would do.
                    if (tmo == TMO_LAST) begin
                        state       <= S_FAIL;
                        o_fail      <= 1'b1;
                        o_busy      <= 1'b0;
                        o_fail_code <= 3'd4;
                    end else begin
                        tmo <= tmo + TW'(1);
                        case (state)
                            S_HUNT: begin
                                if (fall) begin
                                    tmr   <= '0;
                                    state <= S_START;
                                end
                            end
                            S_START: begin
                                if (tmr == HALF_BIT) begin
                                    tmr     <= '0;
                                    bit_idx <= '0;
                                    // High at mid-start means a glitch: resume hunting silently.
                                    state   <= line ? S_HUNT : S_DATA;
                                end else begin
                                    tmr <= tmr + BW'(1);
                                end
                            end
                            S_DATA: begin
                                if (tmr == FULL_BIT) begin
                                    tmr   <= '0;
                                    shreg <= {line, shreg[DATA_BITS-1:1]};
                                    if (bit_idx == LAST_BIT) state <= (PARITY != 0) ? S_PAR : S_STOP;
                                    else bit_idx <= bit_idx + 4'd1;
                                end else begin
                                    tmr <= tmr + BW'(1);
                                end
                            end
                            S_PAR: begin
                                if (tmr == FULL_BIT) begin
                                    tmr     <= '0;
                                    par_bit <= line;
                                    state   <= S_STOP;
                                end else begin
                                    tmr <= tmr + BW'(1);
                                end
                            end
                            S_STOP: begin
                                if (tmr == FULL_BIT) begin
                                    tmr <= '0;
                                    if (!line || par_err) begin
                                        state       <= S_FAIL;
                                        o_fail      <= 1'b1;
                                        o_busy      <= 1'b0;
                                        o_fail_code <= 3'd3;
                                    end else begin
                                        state <= S_CHECK;
                                    end
                                end else begin
                                    tmr <= tmr + BW'(1);
                                end
                            end
                            S_CHECK: begin
                                o_rx_valid <= 1'b1;
                                o_rx_data  <= shreg;
                                if (fifo_empty) begin
                                    state       <= S_FAIL;
                                    o_fail      <= 1'b1;
                                    o_busy      <= 1'b0;
                                    o_fail_code <= 3'd2;
                                end else if (shreg != head) begin
                                    state       <= S_FAIL;
                                    o_fail      <= 1'b1;
                                    o_busy      <= 1'b0;
                                    o_fail_code <= 3'd1;
                                end else begin
                                    rd_ptr     <= rd_ptr + PW'(1);
                                    o_rx_count <= o_rx_count + PW'(1);
                                    tmr        <= '0;
                                    qcnt       <= '0;
                                    // An edge landing in this cycle goes straight to START.
                                    if (last_entry) state <= S_QUIET;
                                    else if (fall)  state <= S_START;
                                    else            state <= S_HUNT;
                                end
                            end
                            S_QUIET: begin
                                if (fall) begin
                                    state       <= S_FAIL;
                                    o_fail      <= 1'b1;
                                    o_busy      <= 1'b0;
                                    o_fail_code <= 3'd2;
                                end else if (line) begin
                                    if (qcnt == QUIET_LAST) begin
                                        state  <= S_PASS;
                                        o_pass <= 1'b1;
                                        o_busy <= 1'b0;
                                    end else begin
                                        qcnt <= qcnt + QW'(1);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_scoreboard.sv
// Bench for uart_scoreboard: two instances, one without parity (pass, mismatch,
// unwanted frame, full FIFO with pointer wrap) and one with even parity and a
// short timeout (parity/stop errors, glitch, timeout, asynchronous reset).
module tb_uart_scoreboard;

    localparam int CLK_DIV   = 104;
    localparam int DW        = 8;
    localparam int DEPTH_A   = 8;
    localparam int DEPTH_B   = 4;
    localparam int QUIET_A   = 3000;
    localparam int QUIET_B   = 200;
    localparam int TMO_A     = 60000;
    localparam int TMO_B     = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic          uart_a = 1'b1, exp_valid_a = 1'b0, arm_a = 1'b0;
    logic [DW-1:0] exp_data_a = '0;
    logic          exp_ready_a, rx_valid_a, busy_a, pass_a, fail_a;
    logic [DW-1:0] rx_data_a;
    logic [3:0]    rx_count_a;
    logic [2:0]    fail_code_a;

    logic          uart_b = 1'b1, exp_valid_b = 1'b0, arm_b = 1'b0;
    logic [DW-1:0] exp_data_b = '0;
    logic          exp_ready_b, rx_valid_b, busy_b, pass_b, fail_b;
    logic [DW-1:0] rx_data_b;
    logic [2:0]    rx_count_b;
    logic [2:0]    fail_code_b;

    // Scoreboard state: characters driven on each line, in order.
    logic [DW-1:0] exp_q_a[$];
    logic [DW-1:0] exp_q_b[$];
    logic [DW-1:0] exp_a, exp_b;
    int            rx_seen_a = 0, rx_seen_b = 0;
    int            last_rx_cyc_a = 0;

    uart_scoreboard #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DW), .PARITY(0), .DEPTH(DEPTH_A),
        .QUIET_CYCLES(QUIET_A), .TIMEOUT_CYCLES(TMO_A)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_uart(uart_a),
        .i_exp_valid(exp_valid_a), .i_exp_data(exp_data_a), .o_exp_ready(exp_ready_a),
        .i_arm(arm_a), .o_rx_valid(rx_valid_a), .o_rx_data(rx_data_a),
        .o_rx_count(rx_count_a), .o_busy(busy_a), .o_pass(pass_a), .o_fail(fail_a),
        .o_fail_code(fail_code_a)
    );

    uart_scoreboard #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DW), .PARITY(1), .DEPTH(DEPTH_B),
        .QUIET_CYCLES(QUIET_B), .TIMEOUT_CYCLES(TMO_B)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_uart(uart_b),
        .i_exp_valid(exp_valid_b), .i_exp_data(exp_data_b), .o_exp_ready(exp_ready_b),
        .i_arm(arm_b), .o_rx_valid(rx_valid_b), .o_rx_data(rx_data_b),
        .o_rx_count(rx_count_b), .o_busy(busy_b), .o_pass(pass_b), .o_fail(fail_b),
        .o_fail_code(fail_code_b)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every received frame must match the next driven character.
    always @(negedge clk) begin
        if (rx_valid_a) begin
            rx_seen_a++;
            last_rx_cyc_a = cyc;
            checks++;
            if (exp_q_a.size() == 0) begin
                errors++;
                $display("FAIL rx_a_unexpected got %h expected none", rx_data_a);
            end else begin
                exp_a = exp_q_a.pop_front();
                if (rx_data_a !== exp_a) begin
                    errors++;
                    $display("FAIL rx_a_data got %h expected %h", rx_data_a, exp_a);
                end
            end
        end
        if (rx_valid_b) begin
            rx_seen_b++;
            checks++;
            if (exp_q_b.size() == 0) begin
                errors++;
                $display("FAIL rx_b_unexpected got %h expected none", rx_data_b);
            end else begin
                exp_b = exp_q_b.pop_front();
                if (rx_data_b !== exp_b) begin
                    errors++;
                    $display("FAIL rx_b_data got %h expected %h", rx_data_b, exp_b);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        uart_a = 1'b1; uart_b = 1'b1;
        exp_valid_a = 1'b0; exp_valid_b = 1'b0;
        arm_a = 1'b0; arm_b = 1'b0;
        exp_q_a.delete(); exp_q_b.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_exp(input int ch, input logic [DW-1:0] d);
        if (ch == 0) begin exp_valid_a = 1'b1; exp_data_a = d; end
        else         begin exp_valid_b = 1'b1; exp_data_b = d; end
        @(negedge clk);
        exp_valid_a = 1'b0; exp_valid_b = 1'b0;
    endtask

    task automatic pulse_arm(input int ch, output int acyc);
        if (ch == 0) arm_a = 1'b1; else arm_b = 1'b1;
        @(negedge clk);
        arm_a = 1'b0; arm_b = 1'b0;
        acyc = cyc;
    endtask

    task automatic drive_bit(input int ch, input logic v);
        if (ch == 0) uart_a = v; else uart_b = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // Start bit, LSB-first data, parity bit (instance b only), stop bit.
    task automatic send_frame(input int ch, input logic [DW-1:0] d, input logic pb, input logic sb);
        drive_bit(ch, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(ch, d[i]);
        if (ch == 1) drive_bit(ch, pb);
        drive_bit(ch, sb);
    endtask

    task automatic wait_verdict(input int ch, input int budget, output int vcyc);
        int n;
        n = 0;
        while (!((ch == 0) ? (pass_a | fail_a) : (pass_b | fail_b)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL verdict_wait ch %0d no verdict within %0d cycles", ch, budget);
        end
        vcyc = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (exp_ready_a !== 1'b1) begin errors++; $display("FAIL reset_exp_ready got %b expected 1", exp_ready_a); end
        checks++; if (rx_valid_a !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid got %b expected 0", rx_valid_a); end
        checks++; if (rx_data_a !== 8'h00)  begin errors++; $display("FAIL reset_rx_data got %h expected 00", rx_data_a); end
        checks++; if (rx_count_a !== 4'd0)  begin errors++; $display("FAIL reset_rx_count got %0d expected 0", rx_count_a); end
        checks++; if ({busy_a, pass_a, fail_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {busy_a, pass_a, fail_a}); end
        checks++; if (fail_code_a !== 3'd0) begin errors++; $display("FAIL reset_fail_code got %0d expected 0", fail_code_a); end
        checks++; if (exp_ready_b !== 1'b1) begin errors++; $display("FAIL reset_exp_ready_b got %b expected 1", exp_ready_b); end
    endtask

    task automatic test_pass_hi();
        int ac, vc;
        do_reset();
        push_exp(0, 8'h48);
        push_exp(0, 8'h69);
        pulse_arm(0, ac);
        checks++; if (busy_a !== 1'b1)      begin errors++; $display("FAIL hi_busy got %b expected 1", busy_a); end
        checks++; if (exp_ready_a !== 1'b0) begin errors++; $display("FAIL hi_ready_armed got %b expected 0", exp_ready_a); end
        repeat (20) @(negedge clk);
        exp_q_a.push_back(8'h48);
        send_frame(0, 8'h48, 1'b0, 1'b1);
        exp_q_a.push_back(8'h69);
        send_frame(0, 8'h69, 1'b0, 1'b1);
        wait_verdict(0, QUIET_A + 500, vc);
        checks++; if (pass_a !== 1'b1 || fail_a !== 1'b0) begin errors++; $display("FAIL hi_verdict got pass %b fail %b expected pass 1 fail 0", pass_a, fail_a); end
        checks++; if (rx_count_a !== 4'd2)  begin errors++; $display("FAIL hi_rx_count got %0d expected 2", rx_count_a); end
        checks++; if (rx_seen_a !== 2)      begin errors++; $display("FAIL hi_rx_pulses got %0d expected 2", rx_seen_a); end
        checks++; if (vc - last_rx_cyc_a !== QUIET_A) begin errors++; $display("FAIL hi_quiet_len got %0d expected %0d", vc - last_rx_cyc_a, QUIET_A); end
        checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL hi_busy_after got %b expected 0", busy_a); end
    endtask

    task automatic test_mismatch();
        int ac, vc;
        do_reset();
        push_exp(0, 8'h55);
        pulse_arm(0, ac);
        repeat (10) @(negedge clk);
        exp_q_a.push_back(8'h54);
        send_frame(0, 8'h54, 1'b0, 1'b1);
        wait_verdict(0, 2000, vc);
        checks++; if (fail_a !== 1'b1 || pass_a !== 1'b0) begin errors++; $display("FAIL mm_verdict got pass %b fail %b expected pass 0 fail 1", pass_a, fail_a); end
        checks++; if (fail_code_a !== 3'd1) begin errors++; $display("FAIL mm_code got %0d expected 1", fail_code_a); end
        checks++; if (rx_data_a !== 8'h54)  begin errors++; $display("FAIL mm_rx_data got %h expected 54", rx_data_a); end
        checks++; if (rx_count_a !== 4'd0)  begin errors++; $display("FAIL mm_rx_count got %0d expected 0", rx_count_a); end
    endtask

    task automatic test_unwanted();
        int ac, vc, seen0;
        do_reset();
        seen0 = rx_seen_a;
        push_exp(0, 8'hA5);
        pulse_arm(0, ac);
        repeat (10) @(negedge clk);
        exp_q_a.push_back(8'hA5);
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        repeat (2000) @(negedge clk);
        send_frame(0, 8'h00, 1'b0, 1'b1);
        wait_verdict(0, 2000, vc);
        checks++; if (fail_a !== 1'b1)      begin errors++; $display("FAIL uw_fail got %b expected 1", fail_a); end
        checks++; if (fail_code_a !== 3'd2) begin errors++; $display("FAIL uw_code got %0d expected 2", fail_code_a); end
        checks++; if (rx_count_a !== 4'd1)  begin errors++; $display("FAIL uw_rx_count got %0d expected 1", rx_count_a); end
        checks++; if (rx_seen_a - seen0 !== 1) begin errors++; $display("FAIL uw_rx_pulses got %0d expected 1", rx_seen_a - seen0); end
    endtask

    task automatic test_parity();
        int ac, vc, seen0;
        do_reset();
        seen0 = rx_seen_b;
        push_exp(1, 8'h03);
        // Bad parity bit (0x03 has even weight, so even parity bit is 0).
        pulse_arm(1, ac);
        repeat (10) @(negedge clk);
        send_frame(1, 8'h03, 1'b1, 1'b1);
        wait_verdict(1, 500, vc);
        checks++; if (fail_b !== 1'b1 || fail_code_b !== 3'd3) begin errors++; $display("FAIL par_bad_parity got fail %b code %0d expected fail 1 code 3", fail_b, fail_code_b); end
        // Correct parity, stop bit low.
        pulse_arm(1, ac);
        checks++; if (fail_b !== 1'b0 || fail_code_b !== 3'd0 || exp_ready_b !== 1'b1) begin errors++; $display("FAIL par_rearm_idle got fail %b code %0d ready %b expected 0 0 1", fail_b, fail_code_b, exp_ready_b); end
        pulse_arm(1, ac);
        repeat (10) @(negedge clk);
        send_frame(1, 8'h03, 1'b0, 1'b0);
        uart_b = 1'b1;
        wait_verdict(1, 500, vc);
        checks++; if (fail_b !== 1'b1 || fail_code_b !== 3'd3) begin errors++; $display("FAIL par_bad_stop got fail %b code %0d expected fail 1 code 3", fail_b, fail_code_b); end
        checks++; if (rx_seen_b !== seen0) begin errors++; $display("FAIL par_no_rx got %0d pulses expected 0", rx_seen_b - seen0); end
        // Well-formed frame against the retained FIFO entry.
        repeat (20) @(negedge clk);
        pulse_arm(1, ac);
        pulse_arm(1, ac);
        repeat (10) @(negedge clk);
        exp_q_b.push_back(8'h03);
        send_frame(1, 8'h03, 1'b0, 1'b1);
        wait_verdict(1, QUIET_B + 500, vc);
        checks++; if (pass_b !== 1'b1 || rx_count_b !== 3'd1) begin errors++; $display("FAIL par_good got pass %b count %0d expected pass 1 count 1", pass_b, rx_count_b); end
    endtask

    task automatic test_full_wrap();
        logic [DW-1:0] vals [DEPTH_A];
        int ac, vc;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                pulse_arm(0, ac);
                checks++; if (exp_ready_a !== 1'b1 || pass_a !== 1'b0) begin errors++; $display("FAIL wrap_rearm got ready %b pass %b expected 1 0", exp_ready_a, pass_a); end
            end
            for (int i = 0; i < DEPTH_A; i++) begin
                vals[i] = DW'($urandom_range(0, 255));
                push_exp(0, vals[i]);
            end
            checks++; if (exp_ready_a !== 1'b0) begin errors++; $display("FAIL wrap_full_ready round %0d got %b expected 0", r, exp_ready_a); end
            push_exp(0, 8'hEE);
            pulse_arm(0, ac);
            repeat (10) @(negedge clk);
            for (int i = 0; i < DEPTH_A; i++) begin
                exp_q_a.push_back(vals[i]);
                send_frame(0, vals[i], 1'b0, 1'b1);
            end
            wait_verdict(0, QUIET_A + 500, vc);
            checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL wrap_pass round %0d got pass %b code %0d expected pass 1", r, pass_a, fail_code_a); end
            checks++; if (rx_count_a !== 4'(DEPTH_A)) begin errors++; $display("FAIL wrap_rx_count round %0d got %0d expected %0d", r, rx_count_a, DEPTH_A); end
            checks++; if (exp_q_a.size() !== 0) begin errors++; $display("FAIL wrap_leftover round %0d got %0d expected 0", r, exp_q_a.size()); end
        end
    endtask

    task automatic test_glitch_timeout();
        int ac, vc, seen0;
        do_reset();
        seen0 = rx_seen_b;
        push_exp(1, 8'h11);
        pulse_arm(1, ac);
        repeat (50) @(negedge clk);
        uart_b = 1'b0;
        repeat (10) @(negedge clk);
        uart_b = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (rx_seen_b !== seen0 || fail_b !== 1'b0) begin errors++; $display("FAIL glitch got pulses %0d fail %b expected 0 0", rx_seen_b - seen0, fail_b); end
        wait_verdict(1, TMO_B + 500, vc);
        checks++; if (fail_b !== 1'b1 || fail_code_b !== 3'd4) begin errors++; $display("FAIL tmo_code got fail %b code %0d expected fail 1 code 4", fail_b, fail_code_b); end
        checks++; if (vc - ac !== TMO_B) begin errors++; $display("FAIL tmo_cycles got %0d expected %0d", vc - ac, TMO_B); end
    endtask

    task automatic test_reset_mid_data();
        int ac;
        do_reset();
        push_exp(1, 8'h5A);
        push_exp(1, 8'h3C);
        pulse_arm(1, ac);
        repeat (10) @(negedge clk);
        exp_q_b.push_back(8'h5A);
        send_frame(1, 8'h5A, 1'b0, 1'b1);
        checks++; if (rx_count_b !== 3'd1 || rx_data_b !== 8'h5A) begin errors++; $display("FAIL mid_pre got count %0d data %h expected 1 5a", rx_count_b, rx_data_b); end
        uart_b = 1'b0;
        repeat (CLK_DIV / 2 + 2 * CLK_DIV) @(negedge clk);
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", busy_b); end
        rst = 1'b1;
        #1;
        checks++; if (exp_ready_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL mid_async_ready_busy got %b %b expected 1 0", exp_ready_b, busy_b); end
        checks++; if (rx_count_b !== 3'd0 || rx_data_b !== 8'h00) begin errors++; $display("FAIL mid_async_rx got count %0d data %h expected 0 00", rx_count_b, rx_data_b); end
        checks++; if ({rx_valid_b, pass_b, fail_b, fail_code_b} !== 6'd0) begin errors++; $display("FAIL mid_async_flags got %b expected 000000", {rx_valid_b, pass_b, fail_b, fail_code_b}); end
        @(negedge clk);
        uart_b = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_pass_hi();
        test_mismatch();
        test_unwanted();
        test_parity();
        test_full_wrap();
        test_glitch_timeout();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case a wait is never satisfied.
    initial begin
        #20_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
